mult_sum_ctrl: RTL and testbench

MULT_SUM_CTRL -- requirements
Module: mult_sum_ctrl

---
 rtl/mult_sum_ctrl_pkg.sv | 13 +
 rtl/mult_sum_ctrl_core.sv | 89 ++++++++
 rtl/mult_sum_ctrl.sv | 111 +++++++++++
 tb/tb_mult_sum_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sum_ctrl_pkg.sv
// Shared state encoding and default widths for the multiple-sum controller.
package mult_sum_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_sum_ctrl_core.sv
// Match/accumulate datapath: term counter, two running-remainder modulo units
// and a carry-tracking accumulator, all loaded from a latched configuration.
module mult_sum_core
  import mult_sum_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [DATA_W-1:0] limit,
  input  logic [DIV_W-1:0]  div_a,
  input  logic [DIV_W-1:0]  div_b,
  output logic [DATA_W-1:0] sum,
  output logic              overflow,
  output logic              last
);

  logic [DATA_W-1:0] limit_r;
  logic [DATA_W-1:0] cnt_r;
  logic [DATA_W-1:0] sum_r;
  logic [DIV_W-1:0]  div_a_r;
  logic [DIV_W-1:0]  div_b_r;
  logic [DIV_W-1:0]  rem_a_r;
  logic [DIV_W-1:0]  rem_b_r;
  logic              ovf_r;

  logic              hit_s;
  logic [DATA_W:0]   add_s;
  logic [DIV_W-1:0]  rem_a_nxt_s;
  logic [DIV_W-1:0]  rem_b_nxt_s;

  // rem_x tracks cnt mod div_x incrementally, so no divider is needed.
  always_comb begin
    hit_s = ((div_a_r != {DIV_W{1'b0}}) && (rem_a_r == {DIV_W{1'b0}})) ||
            ((div_b_r != {DIV_W{1'b0}}) && (rem_b_r == {DIV_W{1'b0}}));
    add_s = {1'b0, sum_r} + {1'b0, cnt_r};
    if (rem_a_r == (div_a_r - DIV_W'(1))) begin
      rem_a_nxt_s = {DIV_W{1'b0}};
    end else begin
      rem_a_nxt_s = rem_a_r + DIV_W'(1);
    end
    if (rem_b_r == (div_b_r - DIV_W'(1))) begin
      rem_b_nxt_s = {DIV_W{1'b0}};
    end else begin
      rem_b_nxt_s = rem_b_r + DIV_W'(1);
    end
  end

  // Configuration latch, term counter and sticky-carry accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      limit_r <= {DATA_W{1'b0}};
      cnt_r   <= {DATA_W{1'b0}};
      sum_r   <= {DATA_W{1'b0}};
      div_a_r <= {DIV_W{1'b0}};
      div_b_r <= {DIV_W{1'b0}};
      rem_a_r <= {DIV_W{1'b0}};
      rem_b_r <= {DIV_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (clear) begin
      limit_r <= limit;
      div_a_r <= div_a;
      div_b_r <= div_b;
      cnt_r   <= {DATA_W{1'b0}};
      sum_r   <= {DATA_W{1'b0}};
      rem_a_r <= {DIV_W{1'b0}};
      rem_b_r <= {DIV_W{1'b0}};
      ovf_r   <= 1'b0;
    end else if (step) begin
      cnt_r   <= cnt_r + DATA_W'(1);
      rem_a_r <= rem_a_nxt_s;
      rem_b_r <= rem_b_nxt_s;
      if (hit_s) begin
        sum_r <= add_s[DATA_W-1:0];
        if (add_s[DATA_W]) begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  assign sum      = sum_r;
  assign overflow = ovf_r;
  assign last     = (cnt_r == (limit_r - DATA_W'(1)));

endmodule

// File: rtl/mult_sum_ctrl.sv
// Job controller: IDLE/RUN/DONE sequencing, start/abort/ack handshakes and
// registered status outputs around the mult_sum_core datapath.
module mult_sum_ctrl
  import mult_sum_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] limit,
  input  logic [DIV_W-1:0]  div_a,
  input  logic [DIV_W-1:0]  div_b,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              overflow,
  input  logic              result_ack
);

  state_e state_r;
  state_e state_nxt_s;
  logic   clear_s;
  logic   step_s;
  logic   last_s;
  logic   ready_r;
  logic   busy_r;
  logic   valid_r;

  mult_sum_core #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_s),
    .step     (step_s),
    .limit    (limit),
    .div_a    (div_a),
    .div_b    (div_b),
    .sum      (result),
    .overflow (overflow),
    .last     (last_s)
  );

  // Next-state and datapath strobes; abort suppresses the final evaluation.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          clear_s = 1'b1;
          if (limit == {DATA_W{1'b0}}) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          step_s = 1'b1;
          if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      DONE: begin
        if (result_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register with status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      busy_r  <= (state_nxt_s == RUN);
      valid_r <= (state_nxt_s == DONE);
    end
  end

  assign ready        = ready_r;
  assign busy         = busy_r;
  assign result_valid = valid_r;

endmodule

// File: tb/tb_mult_sum_ctrl.sv
// Self-checking bench for mult_sum_ctrl: spec vector table, corner sequences
// and random jobs against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_sum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        result_ack;
  logic [31:0] limit;
  logic [7:0]  div_a;
  logic [7:0]  div_b;
  logic        ready;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_sum_ctrl #(.DATA_W(32), .DIV_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .limit        (limit),
    .div_a        (div_a),
    .div_b        (div_b),
    .abort        (abort),
    .ready        (ready),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .result_ack   (result_ack)
  );

  typedef struct {
    logic [31:0] lim;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  // Reference: plain sum over the term range, then split into low word and carry.
  function automatic logic [32:0] model(input logic [31:0] lim, input logic [7:0] a, input logic [7:0] b);
    longint unsigned s;
    longint unsigned la;
    longint unsigned lb;
    s  = 0;
    la = longint'(a);
    lb = longint'(b);
    for (longint unsigned n = 0; n < longint'(lim); n++) begin
      if ((la != 0 && (n % la) == 0) || (lb != 0 && (n % lb) == 0)) s += n;
    end
    return {(s >= 64'h1_0000_0000), s[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [31:0] lim, input logic [7:0] a, input logic [7:0] b,
                         input logic [31:0] exp_res, input logic exp_ovf, input bit glitch, input int hold);
    longint lat;
    int bad;
    @(negedge clk);
    limit = lim; div_a = a; div_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " ready_after_start"}, 64'(ready), 64'(0));
    check({tag, " busy_after_start"}, 64'(busy), 64'(lim != 32'd0));
    lat = 0;
    while (!result_valid && lat <= longint'(lim) + 5) begin
      if (glitch && lat == 5) begin
        start = 1'b1; limit = 32'd10; div_a = 8'd1; div_b = 8'd1; result_ack = 1'b1;
      end else begin
        start = 1'b0; result_ack = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0; result_ack = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(lim));
    check({tag, " valid"}, 64'(result_valid), 64'(1));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        abort = (i == 0);
        @(posedge clk); #1;
        abort = 1'b0;
        if (!result_valid || result !== exp_res || ready || busy) bad++;
      end
      check({tag, " hold_bad_cycles"}, 64'(bad), 64'(0));
    end
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    check({tag, " ready_after_ack"}, 64'(ready), 64'(1));
    check({tag, " valid_after_ack"}, 64'(result_valid), 64'(0));
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (result_valid || !ready) bad++;
    end
    check({tag, " stale_valid_cycles"}, 64'(bad), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [32:0] m;
    logic [31:0] rl;
    logic [7:0]  ra;
    logic [7:0]  rb;

    tbl[0] = '{32'd1000,   8'd3, 8'd5, 32'd233168,    1'b0};
    tbl[1] = '{32'd10,     8'd3, 8'd5, 32'd23,        1'b0};
    tbl[2] = '{32'd0,      8'd3, 8'd5, 32'd0,         1'b0};
    tbl[3] = '{32'd20,     8'd0, 8'd5, 32'd30,        1'b0};
    tbl[4] = '{32'd50,     8'd0, 8'd0, 32'd0,         1'b0};
    tbl[5] = '{32'd100000, 8'd1, 8'd1, 32'd704982704, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
    limit = 32'd0; div_a = 8'd0; div_b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'(1));
    check("reset busy", 64'(busy), 64'(0));
    check("reset valid", 64'(result_valid), 64'(0));
    check("reset overflow", 64'(overflow), 64'(0));
    check("reset result", 64'(result), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), tbl[i].lim, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ovf, 1'b0, 0);
    end

    // Start/ack during RUN ignored; result held 50 cycles with abort tried in DONE.
    run_job("ignore_hold", 32'd1000, 8'd3, 8'd5, 32'd233168, 1'b0, 1'b1, 50);

    // Abort at cycle 500 of a long job.
    @(negedge clk);
    limit = 32'd1000; div_a = 8'd3; div_b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort ready", 64'(ready), 64'(1));
    check("abort busy", 64'(busy), 64'(0));
    check("abort valid", 64'(result_valid), 64'(0));
    watch_no_valid("abort", 1100);
    run_job("after_abort", 32'd10, 8'd3, 8'd5, 32'd23, 1'b0, 1'b0, 0);

    // Abort on the same edge as the final evaluation.
    @(negedge clk);
    limit = 32'd10; div_a = 8'd3; div_b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_last valid", 64'(result_valid), 64'(0));
    check("abort_last ready", 64'(ready), 64'(1));
    watch_no_valid("abort_last", 20);

    // Reset for one edge mid-RUN.
    @(negedge clk);
    limit = 32'd1000; div_a = 8'd1; div_b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst ready", 64'(ready), 64'(1));
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst valid", 64'(result_valid), 64'(0));
    check("midrst overflow", 64'(overflow), 64'(0));
    check("midrst result", 64'(result), 64'(0));
    watch_no_valid("midrst", 1100);

    for (int i = 0; i < 10; i++) begin
      rl = 32'($urandom_range(0, 300));
      ra = 8'($urandom_range(0, 12));
      rb = 8'($urandom_range(0, 12));
      m  = model(rl, ra, rb);
      run_job($sformatf("rand%0d", i), rl, ra, rb, m[31:0], m[32], 1'b0, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
